// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction memory responder: FSM states, NOP
// encoding, default base address and the address range check.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] RV_NOP            = 32'h0000_0013;
  localparam logic [31:0] IMEM_DEFAULT_BASE = 32'h8000_0000;
  localparam int          CNT_W             = 2;

  // Addresses below the base wrap to a large offset, so one compare covers both ends.
  function automatic logic imem_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int          depth);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[1:0] == 2'b00) && ({1'b0, offset} < (33'(depth) << 2));
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch request/response channel plus the side-band program-load port.
interface instr_mem_responder_if;
  logic        req_valid_i;
  logic [31:0] req_address_i;
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_instruction_o;
  logic        resp_error_o;
  logic        resp_ready_i;
  logic        load_enable_i;
  logic [31:0] load_address_i;
  logic [31:0] load_data_i;

  modport slave (
    input  req_valid_i, req_address_i, resp_ready_i,
    input  load_enable_i, load_address_i, load_data_i,
    output req_ready_o, resp_valid_o, resp_instruction_o, resp_error_o
  );

  modport master (
    output req_valid_i, req_address_i, resp_ready_i,
    output load_enable_i, load_address_i, load_data_i,
    input  req_ready_o, resp_valid_o, resp_instruction_o, resp_error_o
  );
endinterface

// File: rtl/instr_mem_responder_array.sv
// DEPTH_WORDS x 32 storage: one synchronous write port, one registered
// read-first read port whose output register clears on reset.
module imem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // Reading mem_q here sees the pre-write value, giving read-first behaviour.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem_q[rd_idx_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Fixed-latency instruction read responder: accepts one fetch, checks the
// address, reads the array on acceptance and holds the response until consumed.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = IMEM_DEFAULT_BASE,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  instr_mem_responder_if.slave bus
);

  localparam int             IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

  imem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             req_ok, ld_ok, rd_en;
  logic [IDX_W-1:0] req_idx, ld_idx;
  logic [31:0]      rd_data;

  assign req_ok  = imem_addr_ok(bus.req_address_i, MEM_BASE, DEPTH_WORDS);
  assign ld_ok   = imem_addr_ok(bus.load_address_i, MEM_BASE, DEPTH_WORDS);
  assign req_idx = IDX_W'((bus.req_address_i - MEM_BASE) >> 2);
  assign ld_idx  = IDX_W'((bus.load_address_i - MEM_BASE) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          rd_en   = req_ok;
          err_d   = !req_ok;
          cnt_d   = CNT_INIT;
          state_d = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (bus.load_enable_i && ld_ok),
    .wr_idx_i  (ld_idx),
    .wr_data_i (bus.load_data_i),
    .rd_en_i   (rd_en),
    .rd_idx_i  (req_idx),
    .rd_data_o (rd_data)
  );

  // The array output only updates on an accepted good read, so it doubles as
  // the held response word; errored requests substitute the NOP.
  assign bus.req_ready_o        = (state_q == IDLE);
  assign bus.resp_valid_o       = (state_q == RESP);
  assign bus.resp_error_o       = err_q;
  assign bus.resp_instruction_o = err_q ? RV_NOP : rd_data;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Runs the same directed program against a READ_LATENCY=1 and a
// READ_LATENCY=3 instance, checked every cycle against a transaction model.
module tb_instr_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic [31:0] req_addr   [2];
  logic        resp_ready [2];
  logic        ld_en      [2];
  logic [31:0] ld_addr    [2];
  logic [31:0] ld_data    [2];
  logic        rdy        [2];
  logic        vld        [2];
  logic        err_o      [2];
  logic [31:0] ins        [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    instr_mem_responder_if bus ();
    assign bus.req_valid_i    = req_valid[g];
    assign bus.req_address_i  = req_addr[g];
    assign bus.resp_ready_i   = resp_ready[g];
    assign bus.load_enable_i  = ld_en[g];
    assign bus.load_address_i = ld_addr[g];
    assign bus.load_data_i    = ld_data[g];
    assign rdy[g]   = bus.req_ready_o;
    assign vld[g]   = bus.resp_valid_o;
    assign err_o[g] = bus.resp_error_o;
    assign ins[g]   = bus.resp_instruction_o;

    instr_mem_responder #(
      .MEM_BASE     (32'h8000_0000),
      .DEPTH_WORDS  (1024),
      .READ_LATENCY (g == 0 ? 1 : 3)
    ) dut (
      .clk_i (clk),
      .rst_i (rst[g]),
      .bus   (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  // Transaction model: word store, and per instance the outstanding request
  // with the edge it was accepted on.
  logic [31:0] mmem   [2][1024];
  bit          m_busy [2];
  bit          m_have [2];
  logic [31:0] m_data [2];
  logic        m_err  [2];
  int          m_acc  [2];
  int          m_cyc  [2];
  bit          started[2];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [lat%0d] actual=%h required=%h t=%0t", nm, lat(g), act, exp, $time);
    end
  endtask

  task automatic model_step(input int g);
    bit          was_busy;
    logic [31:0] off;
    if (rst[g]) begin
      m_busy[g] = 0; m_have[g] = 0; m_data[g] = '0; m_err[g] = 1'b0;
    end else begin
      was_busy = m_busy[g];
      if (m_have[g] && resp_ready[g]) begin
        m_busy[g] = 0; m_have[g] = 0;
      end
      if (!was_busy && req_valid[g]) begin
        off = req_addr[g] - BASE;
        if (req_addr[g][1:0] != 2'b00 || off >= 32'd4096) begin
          m_data[g] = NOP; m_err[g] = 1'b1;
        end else begin
          m_data[g] = mmem[g][off / 4]; m_err[g] = 1'b0;
        end
        m_busy[g] = 1; m_acc[g] = m_cyc[g];
      end
    end
    if (ld_en[g]) begin
      off = ld_addr[g] - BASE;
      if (ld_addr[g][1:0] == 2'b00 && off < 32'd4096) mmem[g][off / 4] = ld_data[g];
    end
    if (m_busy[g] && !m_have[g] && m_cyc[g] >= m_acc[g] + lat(g) - 1) m_have[g] = 1;
    m_cyc[g]++;
  endtask

  task automatic compare(input int g);
    if (!started[g]) return;
    chk("m_ready", g, rdy[g], !m_busy[g]);
    chk("m_valid", g, vld[g], m_have[g]);
    if (m_have[g]) begin
      chk("m_instr", g, ins[g], m_data[g]);
      chk("m_error", g, err_o[g], m_err[g]);
    end
  endtask

  task automatic load(input int g, input logic [31:0] a, input logic [31:0] d);
    ld_en[g] = 1'b1; ld_addr[g] = a; ld_data[g] = d;
    @(negedge clk);
    ld_en[g] = 1'b0;
  endtask

  task automatic wait_ready(input int g, input string nm);
    int n = 0;
    while (!rdy[g] && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_ready"}, g, rdy[g], 1);
  endtask

  // Issue one request; optionally a load to the same address on the acceptance edge.
  task automatic request(input int g, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_e, input string nm,
                         input bit with_ld = 0, input logic [31:0] ld_d = '0);
    int l;
    req_valid[g] = 1'b1; req_addr[g] = a;
    wait_ready(g, nm);
    if (with_ld) begin ld_en[g] = 1'b1; ld_addr[g] = a; ld_data[g] = ld_d; end
    @(negedge clk);
    req_valid[g] = 1'b0; ld_en[g] = 1'b0;
    l = 1;
    while (!vld[g] && l < 20) begin @(negedge clk); l++; end
    chk({nm, "_lat"}, g, l, lat(g));
    chk({nm, "_data"}, g, ins[g], exp_d);
    chk({nm, "_err"}, g, err_o[g], exp_e);
    chk({nm, "_busy"}, g, rdy[g], 0);
    if (resp_ready[g]) @(negedge clk);
  endtask

  task automatic run_seq(input int g);
    logic [31:0] w [4] = '{32'h0010_0093, 32'hDEAD_BEEF, 32'h0030_0193, 32'h0040_0213};
    int  l;
    time tprev;
    repeat (2) @(negedge clk);
    chk("rst_ready", g, rdy[g], 1);
    chk("rst_valid", g, vld[g], 0);
    chk("rst_instr", g, ins[g], 0);
    chk("rst_error", g, err_o[g], 0);
    rst[g] = 1'b0; started[g] = 1;

    load(g, 32'h8000_0000, 32'h0010_0093);
    load(g, 32'h8000_0004, 32'h0020_0113);
    load(g, 32'h8000_0008, 32'h0030_0193);
    load(g, 32'h8000_000C, 32'h0040_0213);
    load(g, 32'h8000_0FFC, 32'h1234_5678);
    // Illegal loads that would alias words 0 and 1023 if not dropped.
    load(g, 32'h8000_0002, 32'hBAD0_0000);
    load(g, 32'h8000_1000, 32'hBAD0_0001);
    load(g, 32'h7FFF_FFFC, 32'hBAD0_0002);

    resp_ready[g] = 1'b1;
    request(g, 32'h8000_0000, 32'h0010_0093, 1'b0, "basic");
    request(g, 32'h8000_0002, NOP, 1'b1, "misalign");
    request(g, 32'h7FFF_FFFC, NOP, 1'b1, "below_base");
    request(g, 32'h8000_1000, NOP, 1'b1, "past_end");
    request(g, 32'h8000_0FFC, 32'h1234_5678, 1'b0, "last_word");

    resp_ready[g] = 1'b0;
    request(g, 32'h8000_0008, 32'h0030_0193, 1'b0, "hold");
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", g, vld[g], 1);
      chk("hold_ready", g, rdy[g], 0);
      chk("hold_instr", g, ins[g], 32'h0030_0193);
    end
    resp_ready[g] = 1'b1;
    @(negedge clk);
    chk("after_hs_ready", g, rdy[g], 1);

    request(g, 32'h8000_0004, 32'h0020_0113, 1'b0, "read_first", 1, 32'hDEAD_BEEF);
    request(g, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, "reread");

    if (lat(g) > 1) begin
      req_valid[g] = 1'b1; req_addr[g] = 32'h8000_0000;
      wait_ready(g, "rst_wait");
      @(negedge clk);
      req_valid[g] = 1'b0;
      chk("in_wait_valid", g, vld[g], 0);
      rst[g] = 1'b1;
      @(negedge clk);
      rst[g] = 1'b0;
      chk("rst_wait_ready", g, rdy[g], 1);
      chk("rst_wait_valid", g, vld[g], 0);
    end

    resp_ready[g] = 1'b0;
    request(g, 32'h8000_000C, 32'h0040_0213, 1'b0, "pre_rst_resp");
    rst[g] = 1'b1;
    @(negedge clk);
    rst[g] = 1'b0;
    chk("rst_resp_ready", g, rdy[g], 1);
    chk("rst_resp_valid", g, vld[g], 0);
    chk("rst_resp_instr", g, ins[g], 0);
    chk("rst_resp_error", g, err_o[g], 0);
    resp_ready[g] = 1'b1;
    request(g, 32'h8000_0000, 32'h0010_0093, 1'b0, "kept_after_rst");

    req_valid[g] = 1'b1;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      req_addr[g] = BASE + 32'(4 * i);
      wait_ready(g, "b2b");
      if (i > 0) chk("b2b_gap", g, 32'(($time - tprev) / 10), lat(g) + 1);
      tprev = $time;
      @(negedge clk);
      l = 1;
      while (!vld[g] && l < 20) begin @(negedge clk); l++; end
      chk("b2b_data", g, ins[g], w[i]);
      @(negedge clk);
    end
    req_valid[g] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; req_valid[g] = 1'b0; req_addr[g] = '0; resp_ready[g] = 1'b0;
      ld_en[g] = 1'b0; ld_addr[g] = '0; ld_data[g] = '0;
      m_busy[g] = 0; m_have[g] = 0; m_data[g] = '0; m_err[g] = 1'b0;
      m_acc[g] = 0; m_cyc[g] = 0; started[g] = 0;
    end
    fork
      forever @(posedge clk) for (int g = 0; g < 2; g++) model_step(g);
      forever @(negedge clk) for (int g = 0; g < 2; g++) compare(g);
    join_none
    fork
      run_seq(0);
      run_seq(1);
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
